// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// muldiv_seq : 32-iteration sequential MUL/MULTU/DIV/DIVU unit with HI/LO.
// Optional macro DIV_ZERO_DETECT_EN: short-circuit divide-by-zero, flag div0.
// Revision: 1.0
// ============================================================================
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sgn_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign sgn_op    = ~op[0];
  assign a_mag     = (sgn_op && a[31]) ? (~a + 32'd1) : a;
  assign b_mag     = (sgn_op && b[31]) ? (~b + 32'd1) : b;
  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, b_q};
  // Restoring divide: upper half holds the remainder, lower half shifts dividend out / quotient in
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign prod_fix  = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix   = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix   = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

`ifdef DIV_ZERO_DETECT_EN
  logic dz_q, dz_d;
  logic div0_q, div0_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    dz_d     = dz_q;
    div0_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          b_d      = b_mag;
          acc_d    = {32'd0, a_mag};
          neg_lo_d = sgn_op & (a[31] ^ b[31]);
          neg_hi_d = sgn_op & a[31];
          cnt_d    = 5'd0;
          state_d  = CALC;
`ifdef DIV_ZERO_DETECT_EN
          dz_d = op[1] && (b == 32'd0);
          if (op[1] && (b == 32'd0)) state_d = FIX;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          acc_d = {(div_diff[32] ? div_shift[31:0] : div_diff[31:0]),
                   acc_q[30:0], ~div_diff[32]};
        end else if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[31:1]};
        end else begin
          acc_d = {1'b0, acc_q[63:32], acc_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
        div0_d  = dz_q;
        if (!dz_q) begin
`else
        begin
`endif
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q     <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q     <= dz_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// tb_muldiv_seq : directed-vector scoreboard bench for muldiv_seq.
// Revision: 1.0
// ============================================================================
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  localparam logic [1:0] MUL = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div0", {31'd0, div0}, {31'd0, e.div0});
        chk("latency", cyc - e.issue, e.lat);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL busy_timeout: got busy=1 expected 0");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input logic ediv0, input int elat);
    exp_t e;
    @(negedge clk);
    e.hi = ehi; e.lo = elo; e.div0 = ediv0; e.lat = elat; e.issue = cyc;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);
    rst = 1'b0;

    // Idle MTHI, then MTHI+MTLO together
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_done", {31'd0, done}, 32'd0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'h0BADF00D);
    chk("mtboth_lo", lo, 32'h0BADF00D);

    run(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    run(MUL,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    run(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
    run(DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
    run(MUL,   32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
    run(MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34);

    // DIVU with start and mthi re-asserted mid-operation
    @(negedge clk);
    e.hi = 32'd2; e.lo = 32'd14; e.div0 = 1'b0; e.lat = 34; e.issue = cyc;
    sb.push_back(e);
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd3; mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_idle();

`ifdef DIV_ZERO_DETECT_EN
    run(DIVU, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 2);
`else
    run(DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, 34);
`endif

    // start + mthi together: mthi lands at once, product overwrites at FIX
    @(negedge clk);
    e.hi = 32'd0; e.lo = 32'd12; e.div0 = 1'b0; e.lat = 34; e.issue = cyc;
    sb.push_back(e);
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4; mthi = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("mthi_with_start", hi, 32'hDEADBEEF);
    wait_idle();

    // Reset 10 cycles into a MULTU: no done, HI/LO cleared
    run(MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 34);
    issue(MULTU, 32'hFFFFFFFF, 32'h2);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    repeat (40) @(negedge clk);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Port `clk`  in  1: rising-edge clock for all state.
REQ-003 Port `rst`  in  1: synchronous active-high reset.
REQ-004 Port `start`  in  1: request a multiply/divide operation, sampled at the clk edge.
REQ-005 Port `op`  in  2: operation select; 00 MUL (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port `a`  in  32: rs operand; multiplicand or dividend.
REQ-007 Port `b`  in  32: rt operand; multiplier or divisor.
REQ-008 Port `mthi`  in  1: write `wdata` to HI.
REQ-009 Port `mtlo`  in  1: write `wdata` to LO.
REQ-010 Port `wdata`  in  32: data for MTHI/MTLO.
REQ-011 Port `busy`  out  1: operation in progress; the pipeline stalls on it.
REQ-012 Port `done`  out  1: one-cycle pulse when HI/LO hold a new result.
REQ-013 Port `hi`  out  32: HI register.
REQ-014 Port `lo`  out  32: LO register.
REQ-015 Port `div0`  out  1: divide-by-zero pulse, coincident with `done`.

Function
REQ-016 The FSM SHALL have states IDLE, CALC and FIX; `busy` SHALL be 1 in every state except IDLE.
REQ-017 In IDLE with start=1 at edge E0, the block SHALL latch op, the operand magnitudes (|a|, |b| for signed ops, raw values for unsigned ops) and the result signs, clear the 5-bit iteration counter, and enter CALC.
REQ-018 CALC SHALL perform one iteration per edge over E1..E32, then enter FIX at E32.
- Multiply: shift-add, one multiplier bit per iteration, 64-bit accumulator.
- Divide: restoring, one quotient bit per iteration, 33-bit partial remainder.
REQ-019 At E33 (FIX), the block SHALL apply sign correction, write HI/LO, return to IDLE, and drive done=1 for the following cycle only.
- Total latency: `busy` high 34 cycles; results visible together with `done`.
REQ-020 MUL/MULTU SHALL produce {hi,lo} = the 64-bit product; MUL treats both operands as two's complement.
REQ-021 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
- Signed: quotient truncated toward zero; remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF (signed) SHALL give lo=0x80000000, hi=0.
REQ-022 `start` while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 `mthi`/`mtlo` while busy=1 SHALL be ignored.
REQ-024 `mthi`/`mtlo` in IDLE SHALL update HI/LO at the next edge; `done` does not pulse for these writes.
REQ-025 When `start` and `mthi`/`mtlo` are asserted together in IDLE, both SHALL take effect; the operation result overwrites HI/LO at FIX.
REQ-026 When `mthi` and `mtlo` are asserted together, both registers SHALL be written with `wdata`.
REQ-027 When DIV_ZERO_DETECT_EN is undefined, `div0` SHALL be constant 0.

Reset
REQ-028 When rst=1 at an edge, the block SHALL clear state (IDLE), counter, hi, lo, busy, done and div0 to 0.
REQ-029 Reset SHALL take priority over start, mthi and mtlo.
REQ-030 Reset mid-operation SHALL abandon the operation with no `done` pulse, and HI/LO SHALL read 0.

Configuration
REQ-031 With macro DIV_ZERO_DETECT_EN defined, DIV/DIVU with b=0 SHALL skip CALC and go IDLE -> FIX at E0.
- At E1: return to IDLE, leave hi/lo unchanged, pulse done=1 and div0=1; `busy` high 2 cycles.
REQ-032 Without DIV_ZERO_DETECT_EN, b=0 SHALL run the full 34-cycle sequence.
- Magnitude result: quotient 0xFFFFFFFF, remainder |a|; sign correction per REQ-021 then applies.
- DIVU 5/0 gives lo=0xFFFFFFFF, hi=5.

Verification
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 busy cycles, done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MUL a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU a=100, b=7 with start re-asserted and mthi (wdata=0x1234) pulsed mid-operation -> ignored; lo=14, hi=2, a single done pulse.
REQ-036 Idle: mthi=1, wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5 at next edge, done stays 0; then rst asserted 10 cycles into a MULTU -> busy=0, hi=lo=0, no done.
REQ-037 DIVU a=5, b=0 -> with DIV_ZERO_DETECT_EN: done=div0=1 two cycles after start, hi/lo unchanged; without the macro: 34 cycles, lo=0xFFFFFFFF, hi=5, div0=0.
